// File: rtl/count_sequence_arbiter_if.sv
// Requester and shared-counter signals of count_sequence_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface count_sequence_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] limit0;
   logic [WIDTH-1:0] limit1;
   logic             hold;
   logic [WIDTH-1:0] count;
   logic             cnt_clear;
   logic             count_enable;
   logic [1:0]       grant;
   logic             done0;
   logic             done1;
   logic             busy;

   modport slave (
      input  req0, req1, limit0, limit1, hold, count,
      output cnt_clear, count_enable, grant, done0, done1, busy
   );

   modport master (
      output req0, req1, limit0, limit1, hold, count,
      input  cnt_clear, count_enable, grant, done0, done1, busy
   );
endinterface

// File: rtl/count_sequence_arbiter.sv
// Shares one external counter between two requesters and sequences each counting run.
// Optional macro SEQ_FIXED_PRIORITY_EN: req0 always wins ties (default: round-robin).
//
// Handshake: a requester raises reqN and holds it, together with a stable limitN,
// until it sees a one-cycle doneN; it drops reqN the following cycle. Dropping reqN
// earlier aborts the run without a done pulse. grant is the one-hot owner, 00 when free.
module count_sequence_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   count_sequence_arbiter_if.slave bus,
   output logic [1:0]              fsm_state
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic             at_limit;
   logic             pick1;
   logic             owner_req;
   logic [WIDTH-1:0] next_count;

   assign owner_req  = bus.grant[1] ? bus.req1 : bus.req0;
   // Counter value after this edge, given the enable it is seeing right now.
   assign next_count = bus.count_enable ? bus.count + WIDTH'(1) : bus.count;

`ifdef SEQ_FIXED_PRIORITY_EN
   assign pick1 = bus.req1 && !bus.req0;
`else
   logic prefer1;
   logic run_release;

   assign run_release = (state == DONE) ||
                        (((state == CLEAR) || (state == RUN)) && !owner_req);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prefer1 <= 1'b0;
      end else if (run_release) begin
         prefer1 <= bus.grant[0];
      end
   end

   assign pick1 = bus.req1 && (!bus.req0 || prefer1);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         limit_q          <= '0;
         at_limit         <= 1'b0;
         bus.cnt_clear    <= 1'b0;
         bus.count_enable <= 1'b0;
         bus.grant        <= 2'b00;
         bus.done0        <= 1'b0;
         bus.done1        <= 1'b0;
      end else begin
         bus.cnt_clear <= 1'b0;
         bus.done0     <= 1'b0;
         bus.done1     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state         <= CLEAR;
                  bus.cnt_clear <= 1'b1;
                  at_limit      <= 1'b0;
                  bus.grant     <= pick1 ? 2'b10 : 2'b01;
                  limit_q       <= pick1 ? bus.limit1 : bus.limit0;
               end
            end
            CLEAR: begin
               bus.count_enable <= 1'b0;
               if (!owner_req) begin
                  state     <= IDLE;
                  bus.grant <= 2'b00;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!owner_req) begin
                  state            <= IDLE;
                  bus.grant        <= 2'b00;
                  bus.count_enable <= 1'b0;
               end else if (at_limit && (bus.count == limit_q)) begin
                  state            <= DONE;
                  bus.count_enable <= 1'b0;
                  bus.done0        <= bus.grant[0];
                  bus.done1        <= bus.grant[1];
               end else begin
                  // Enable is registered, so it must look one increment ahead to stop on the limit.
                  bus.count_enable <= !bus.hold && (next_count != limit_q);
                  at_limit         <= (next_count == limit_q);
               end
            end
            DONE: begin
               state     <= IDLE;
               bus.grant <= 2'b00;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign fsm_state = state;
endmodule
